hyperbus_responder: RTL and testbench
=====================================

Name: hyperbus_responder

Overview:
- Synthesizable HyperBus memory-device responder: the device end of the link driven by our HyperBus controller PHY.
- Decodes the 48-bit command-address (CA), applies access latency and serves linear/wrapped bursts from an internal word array.
- Also serves the register space: ID0/ID1 read-only, CR0 read/write.
- Works on an SDR-folded bus: one clk_i cycle equals one HyperBus CK period. Bits [15:8] are the CK-rising byte, [7:0] the falling byte.
- Used as the FPGA/emulation memory model and as the loopback target for controller verification.

Parameters:
- MEM_WORDS, 4096, 16-bit words in the array; power of two; the address wraps modulo MEM_WORDS.
- ID0_VAL, 16'h0C81, value returned for register address 0x0000.
- ID1_VAL, 16'h0001, value returned for register address 0x0001.
- CR0_RST, 16'h8F1F, reset value of CR0.

Ports:
- clk_i  in  1  clock; one cycle per HyperBus CK period.
- rst_i  in  1  synchronous, active-high reset.
- cs_ni  in  1  chip select, active low.
- dq_i  in  16  folded DQ input: {rising byte, falling byte}.
- rwds_i  in  2  write byte mask, 1 = byte masked; [1] applies to dq_i[15:8].
- refresh_req_i  in  1  pending-refresh flag; requests additional latency.
- dq_o  out  16  folded read data.
- dq_oe_o  out  1  DQ output enable.
- rwds_o  out  2  RWDS drive value: [1] rising half, [0] falling half.
- rwds_oe_o  out  1  RWDS output enable.

Behaviour:
- Reset: state IDLE, CR0=CR0_RST, dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0. All outputs are registered.
- Cycle numbering: C0 is the first cycle with cs_ni=0 seen in IDLE.
- CA capture:
  - C0 captures CA[47:32], C1 captures CA[31:16], C2 captures CA[15:0].
  - CA[47]=1 read; CA[46]=1 register space; CA[45]=1 linear burst, 0 wrapped.
  - Word address = {CA[44:16], CA[2:0]} mod MEM_WORDS (register space: low 16 bits).
- Latency signalling:
  - During C0..C2: rwds_oe_o=1 and rwds_o={X,X}, where X = CR0[3] | refresh_req_i sampled at C0.
  - X is latched at C0 as dbl.
- Latency L:
  - Base latency from CR0[7:4]: 0000=5, 0001=6, 0010=7, 1110=3, 1111=4; other codes treated as 6.
  - L = base if dbl=0, else 2*base.
- Register write (CA[47]=0, CA[46]=1):
  - Zero latency; dq_i is sampled at C3.
  - If address==0x0800, CR0 <= dq_i. Any other address is ignored.
  - Then state DONE until cs_ni=1.
- Memory write:
  - LAT counts C3..C(2+L).
  - WR samples data at C(3+L)+k for k>=0, while cs_ni=0.
  - Byte write with rwds_i mask; address increments each beat.
- Read (memory or register):
  - LAT counts as for writes.
  - The RD output register is loaded at the end of each cycle, so dq_o in cycle C(3+L)+k holds word k.
  - During those cycles: dq_oe_o=1, rwds_oe_o=1, rwds_o=2'b10.
  - Register reads: 0x0000→ID0_VAL, 0x0001→ID1_VAL, 0x0800→CR0, others→16'h0000.
  - The register address does not advance.
- Burst addressing:
  - Linear: addr+1 mod MEM_WORDS.
  - Wrapped: the low bits wrap within the group from CR0[1:0]: 00=64, 01=32, 10=8, 11=16 words; the upper bits are held.
- States: IDLE→CA (C0)→{REG_WR | LAT}; LAT→{RD | WR} when the count expires; RD/WR stay until cs_ni=1; REG_WR→DONE.
- cs_ni=1 in any state:
  - Next state is IDLE and all enables drop on the next edge.
  - A partial CA or latency is discarded; no memory or CR0 write occurs in that cycle.
- rst_i mid-transaction: immediate return to reset values; memory contents are preserved, CR0 is reset.
- refresh_req_i is ignored outside C0.

Decomposition:
- hyperbus_pkg holds the shared definitions:
  - CA struct typedef (rw, as, burst_type, row/col fields);
  - state enum;
  - register address constants (ID0=0x0000, ID1=0x0001, CR0=0x0800);
  - the latency-code decode function;
  - the wrap-mask function.
- Sub-module hyperbus_resp_mem: single-port MEM_WORDS x 16 array with a 2-bit byte-enable write and a synchronous read into the output register.

Test Plan:
- Reset, CR0 read: CA=16'hC000,16'h0100,16'h0000 (register read 0x0800), refresh_req_i=0. Expected: rwds_o=2'b11 during CA; dq_o=16'h8F1F at C15 (L=12).
- Memory write then linear read:
  - Write 4 words at word address 0x10: A5A5, 1234, BEEF, 0F0F, with rwds_i=2'b01 on beat 2 so only 8'hBE is written.
  - Read back 4 words from 0x10 (prior contents 0). Expected: A5A5, 1234, BE00, 0F0F.
- CR0 write:
  - Register write at 0x0800 with 16'h8E17 (base 6, variable latency, 16-word wrap).
  - Read with refresh_req_i=0. Expected: rwds_o=2'b00 in CA; first read data at C9 (L=6).
  - Same read with refresh_req_i=1. Expected: first data at C15 (L=12).
- Wrapped burst: CR0=8E17, wrapped read of 18 beats from word 0x1E. Expected address order 0x1E, 0x1F, 0x10, ..., 0x1F; beats 16-17 return 0x1E, 0x1F.
- Abort mid-latency: cs_ni=1 at C5 of a write. Expected: state IDLE at C6, dq_oe_o=0; a subsequent read shows memory unchanged.
- Sync reset during RD beat 2: rst_i=1 for one cycle. Expected: dq_oe_o=0 and rwds_oe_o=0 next cycle; CR0=8F1F; the next transaction decodes normally.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus responder definitions: CA layout, FSM states, register map,
// latency-code decode and wrapped-burst group mask.
package hyperbus_pkg;

  typedef struct packed {
    logic        rw;          // 1 = read
    logic        as;          // 1 = register space
    logic        burst_type;  // 1 = linear, 0 = wrapped
    logic [28:0] row;         // CA[44:16]
    logic [12:0] rsvd;        // CA[15:3]
    logic [2:0]  col;         // CA[2:0]
  } ca_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RD,
    ST_WR,
    ST_REG_WR,
    ST_DONE
  } state_t;

  localparam logic [15:0] REG_ID0 = 16'h0000;
  localparam logic [15:0] REG_ID1 = 16'h0001;
  localparam logic [15:0] REG_CR0 = 16'h0800;

  function automatic logic [3:0] lat_base(input logic [3:0] code);
    case (code)
      4'b0000: return 4'd5;
      4'b0001: return 4'd6;
      4'b0010: return 4'd7;
      4'b1110: return 4'd3;
      4'b1111: return 4'd4;
      default: return 4'd6;
    endcase
  endfunction

  // Mask of the address bits that wrap inside the burst group.
  function automatic logic [6:0] wrap_mask(input logic [1:0] code);
    case (code)
      2'b00:   return 7'd63;
      2'b01:   return 7'd31;
      2'b10:   return 7'd7;
      default: return 7'd15;
    endcase
  endfunction

endpackage

// File: rtl/hyperbus_resp_mem.sv
// Single-port word array with per-byte write enables and a registered read port;
// the read register can instead load a bypass word (register-space reads).
module hyperbus_resp_mem #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    be,
  input  logic [15:0]   wdat,
  input  logic          rd,
  input  logic          byp,
  input  logic [15:0]   byp_dat,
  output logic [15:0]   rdat
);

  logic [15:0] mem [WORDS];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (be[1]) mem[addr][15:8] <= wdat[15:8];
    if (be[0]) mem[addr][7:0]  <= wdat[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst)     rdat <= '0;
    else if (rd) rdat <= byp ? byp_dat : mem[addr];
  end

endmodule

// File: rtl/hyperbus_responder.sv
// HyperBus device-side responder on an SDR-folded bus: CA decode, latency,
// linear/wrapped memory bursts and the ID0/ID1/CR0 register space.
module hyperbus_responder
  import hyperbus_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [15:0] ID0_VAL   = 16'h0C81,
  parameter logic [15:0] ID1_VAL   = 16'h0001,
  parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_ni,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  input  logic        refresh_req_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        state_q, state_d;
  logic [47:0]   ca_q, ca_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          dbl_q, dbl_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt, wmask;
  logic [15:0]   cr0_q, cr0_d, reg_rd;
  logic          dq_oe_d, rwds_oe_d;
  logic [1:0]    rwds_d, mem_be;
  logic          mem_rd, mem_byp;
  logic [4:0]    lat;
  logic [15:0]   reg_addr;
  ca_t           ca, ca_in;
  logic          unused_bits;

  assign ca       = ca_q;
  assign ca_in    = {ca_q[47:16], dq_i};  // full CA as it completes in the last CA cycle
  assign reg_addr = {ca.row[12:0], ca.col};
  assign lat      = dbl_q ? {lat_base(cr0_q[7:4]), 1'b0} : {1'b0, lat_base(cr0_q[7:4])};
  assign wmask    = AW'(wrap_mask(cr0_q[1:0]));
  assign addr_nxt = ca.burst_type ? addr_q + AW'(1)
                                  : (addr_q & ~wmask) | ((addr_q + AW'(1)) & wmask);
  assign unused_bits = ^{ca.rsvd, ca.row[28:13], ca_in.rsvd, ca_in.burst_type};

  always_comb begin
    reg_rd = 16'h0000;
    case (reg_addr)
      REG_ID0: reg_rd = ID0_VAL;
      REG_ID1: reg_rd = ID1_VAL;
      REG_CR0: reg_rd = cr0_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ca_d      = ca_q;
    cnt_d     = cnt_q;
    dbl_d     = dbl_q;
    addr_d    = addr_q;
    cr0_d     = cr0_q;
    dq_oe_d   = 1'b0;
    rwds_d    = 2'b00;
    rwds_oe_d = 1'b0;
    mem_be    = 2'b00;
    mem_rd    = 1'b0;
    mem_byp   = 1'b0;
    if (cs_ni) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_CA;
          ca_d[47:32]  = dq_i;
          dbl_d        = cr0_q[3] | refresh_req_i;
          cnt_d        = 5'd1;
          rwds_oe_d    = 1'b1;
          rwds_d       = {2{dbl_d}};
        end
        ST_CA: begin
          rwds_oe_d = 1'b1;
          rwds_d    = {2{dbl_q}};
          if (cnt_q == 5'd1) begin
            ca_d[31:16] = dq_i;
            cnt_d       = 5'd2;
          end else begin
            ca_d[15:0] = dq_i;
            addr_d     = AW'({ca_in.row, ca_in.col});
            if (!ca_in.rw && ca_in.as) begin
              state_d = ST_REG_WR;
            end else begin
              state_d = ST_LAT;
              cnt_d   = lat - 5'd1;
            end
          end
        end
        ST_LAT: begin
          if (cnt_q == 5'd0) state_d = ca.rw ? ST_RD : ST_WR;
          else               cnt_d   = cnt_q - 5'd1;
        end
        ST_RD: begin
          mem_rd    = 1'b1;
          mem_byp   = ca.as;
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          rwds_d    = 2'b10;
          if (!ca.as) addr_d = addr_nxt;
        end
        ST_WR: begin
          mem_be = ~rwds_i;
          addr_d = addr_nxt;
        end
        ST_REG_WR: begin
          if (reg_addr == REG_CR0) cr0_d = dq_i;
          state_d = ST_DONE;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ca_q      <= '0;
      cnt_q     <= '0;
      dbl_q     <= 1'b0;
      addr_q    <= '0;
      cr0_q     <= CR0_RST;
      dq_oe_o   <= 1'b0;
      rwds_o    <= 2'b00;
      rwds_oe_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      ca_q      <= ca_d;
      cnt_q     <= cnt_d;
      dbl_q     <= dbl_d;
      addr_q    <= addr_d;
      cr0_q     <= cr0_d;
      dq_oe_o   <= dq_oe_d;
      rwds_o    <= rwds_d;
      rwds_oe_o <= rwds_oe_d;
    end
  end

  hyperbus_resp_mem #(.WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk     (clk_i),
    .rst     (rst_i),
    .addr    (addr_q),
    .be      (mem_be & {2{~rst_i}}),
    .wdat    (dq_i),
    .rd      (mem_rd),
    .byp     (mem_byp),
    .byp_dat (reg_rd),
    .rdat    (dq_o)
  );

endmodule

// File: tb/tb_hyperbus_responder.sv
// Directed bench for hyperbus_responder: cycle Cn inputs are driven before
// posedge n and the outputs registered at that edge are sampled 1 time unit later.
module tb_hyperbus_responder;

  logic        clk = 1'b0;
  logic        rst_i, cs_ni, refresh_req_i;
  logic [15:0] dq_i;
  logic [1:0]  rwds_i;
  logic [15:0] dq_o;
  logic        dq_oe_o, rwds_oe_o;
  logic [1:0]  rwds_o;

  hyperbus_responder dut (
    .clk_i(clk), .rst_i(rst_i), .cs_ni(cs_ni), .dq_i(dq_i), .rwds_i(rwds_i),
    .refresh_req_i(refresh_req_i), .dq_o(dq_o), .dq_oe_o(dq_oe_o),
    .rwds_o(rwds_o), .rwds_oe_o(rwds_oe_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          rd_bad;
  logic [15:0] rd_dat [32];
  logic [15:0] wr_dat [32];
  logic [1:0]  wr_msk [32];
  logic [1:0]  rec_rwds [3];
  logic        rec_oe [3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives C0..C2; refresh is flipped after C0, where the device must ignore it.
  task automatic drive_ca(input logic [15:0] c0, c1, c2, input logic rf);
    cs_ni = 1'b0; dq_i = c0; refresh_req_i = rf;
    tick; rec_rwds[0] = rwds_o; rec_oe[0] = rwds_oe_o;
    refresh_req_i = ~rf;
    dq_i = c1;
    tick; rec_rwds[1] = rwds_o; rec_oe[1] = rwds_oe_o;
    dq_i = c2;
    tick; rec_rwds[2] = rwds_o; rec_oe[2] = rwds_oe_o;
  endtask

  task automatic do_read(input logic [15:0] c0, c1, c2, input logic rf,
                         input int nbeats, output int first);
    int got = 0;
    first = -1;
    rd_bad = 0;
    for (int i = 0; i < 32; i++) rd_dat[i] = 16'hxxxx;
    drive_ca(c0, c1, c2, rf);
    dq_i = 16'h0;
    for (int n = 3; n < 60 && got < nbeats; n++) begin
      tick;
      if (dq_oe_o === 1'b1) begin
        if (first < 0) first = n;
        if (rwds_o !== 2'b10 || rwds_oe_o !== 1'b1) rd_bad++;
        rd_dat[got] = dq_o;
        got++;
      end
    end
    cs_ni = 1'b1; refresh_req_i = 1'b0;
    tick;
  endtask

  task automatic do_write(input logic [15:0] c0, c1, c2, input int lat, input int nbeats);
    drive_ca(c0, c1, c2, 1'b0);
    for (int i = 0; i < lat; i++) begin
      dq_i = 16'h0;
      tick;
    end
    for (int k = 0; k < nbeats; k++) begin
      dq_i = wr_dat[k]; rwds_i = wr_msk[k];
      tick;
    end
    cs_ni = 1'b1; rwds_i = 2'b00; refresh_req_i = 1'b0;
    tick;
  endtask

  task automatic reg_write(input logic [15:0] c2, input logic [15:0] val);
    drive_ca(16'h6000, 16'h0100, c2, 1'b0);
    dq_i = val;
    tick;
    cs_ni = 1'b1; refresh_req_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    int first;
    rst_i = 1'b1; cs_ni = 1'b1; dq_i = 16'h0; rwds_i = 2'b00; refresh_req_i = 1'b0;
    tick; tick;
    checks++; if (dq_o !== 16'h0) begin failures++; $display("FAIL reset_dq: got %h want 0000", dq_o); end
    checks++; if (dq_oe_o !== 1'b0) begin failures++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe_o); end
    checks++; if (rwds_o !== 2'b00) begin failures++; $display("FAIL reset_rwds: got %b want 00", rwds_o); end
    checks++; if (rwds_oe_o !== 1'b0) begin failures++; $display("FAIL reset_rwds_oe: got %b want 0", rwds_oe_o); end
    rst_i = 1'b0;
    tick;
    do_read(16'hC000, 16'h0100, 16'h0000, 1'b0, 1, first);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rec_rwds[i] !== 2'b11) begin failures++; $display("FAIL reset_ca_rwds C%0d: got %b want 11", i, rec_rwds[i]); end
      checks++; if (rec_oe[i] !== 1'b1) begin failures++; $display("FAIL reset_ca_rwds_oe C%0d: got %b want 1", i, rec_oe[i]); end
    end
    checks++; if (first !== 15) begin failures++; $display("FAIL reset_cr0_first: got C%0d want C15", first); end
    checks++; if (rd_dat[0] !== 16'h8F1F) begin failures++; $display("FAIL reset_cr0_val: got %h want 8f1f", rd_dat[0]); end
  endtask

  task automatic test_write_linear;
    int first;
    logic [15:0] exp [4];
    exp[0] = 16'hA5A5; exp[1] = 16'h1234; exp[2] = 16'hBE00; exp[3] = 16'h0F0F;
    for (int k = 0; k < 4; k++) begin wr_dat[k] = 16'h0000; wr_msk[k] = 2'b00; end
    do_write(16'h2000, 16'h0002, 16'h0000, 12, 4);
    wr_dat[0] = 16'hA5A5; wr_dat[1] = 16'h1234; wr_dat[2] = 16'hBEEF; wr_dat[3] = 16'h0F0F;
    wr_msk[2] = 2'b01;
    do_write(16'h2000, 16'h0002, 16'h0000, 12, 4);
    do_read(16'hA000, 16'h0002, 16'h0000, 1'b0, 4, first);
    checks++; if (first !== 15) begin failures++; $display("FAIL lin_first: got C%0d want C15", first); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_dat[k] !== exp[k]) begin failures++; $display("FAIL lin_beat%0d: got %h want %h", k, rd_dat[k], exp[k]); end
    end
  endtask

  task automatic test_cr0_write;
    int first;
    reg_write(16'h0000, 16'h8E17);
    reg_write(16'h0001, 16'h1234);
    do_read(16'hC000, 16'h0100, 16'h0000, 1'b0, 2, first);
    checks++; if (rec_rwds[0] !== 2'b00) begin failures++; $display("FAIL cr0_ca_rwds: got %b want 00", rec_rwds[0]); end
    checks++; if (first !== 9) begin failures++; $display("FAIL cr0_first: got C%0d want C9", first); end
    checks++; if (rd_dat[0] !== 16'h8E17) begin failures++; $display("FAIL cr0_val: got %h want 8e17", rd_dat[0]); end
    checks++; if (rd_dat[1] !== 16'h8E17) begin failures++; $display("FAIL cr0_beat1: got %h want 8e17", rd_dat[1]); end
    do_read(16'hC000, 16'h0100, 16'h0000, 1'b1, 1, first);
    checks++; if (rec_rwds[0] !== 2'b11) begin failures++; $display("FAIL cr0_ref_ca_rwds: got %b want 11", rec_rwds[0]); end
    checks++; if (first !== 15) begin failures++; $display("FAIL cr0_ref_first: got C%0d want C15", first); end
    checks++; if (rd_dat[0] !== 16'h8E17) begin failures++; $display("FAIL cr0_ref_val: got %h want 8e17", rd_dat[0]); end
    do_read(16'hC000, 16'h0000, 16'h0000, 1'b0, 1, first);
    checks++; if (rd_dat[0] !== 16'h0C81) begin failures++; $display("FAIL id0_val: got %h want 0c81", rd_dat[0]); end
    do_read(16'hC000, 16'h0000, 16'h0001, 1'b0, 1, first);
    checks++; if (rd_dat[0] !== 16'h0001) begin failures++; $display("FAIL id1_val: got %h want 0001", rd_dat[0]); end
  endtask

  task automatic test_wrap;
    int first;
    logic [15:0] want;
    for (int k = 0; k < 16; k++) begin wr_dat[k] = 16'h1000 + 16'(k); wr_msk[k] = 2'b00; end
    do_write(16'h2000, 16'h0002, 16'h0000, 6, 16);
    do_read(16'h8000, 16'h0003, 16'h0006, 1'b0, 18, first);
    checks++; if (first !== 9) begin failures++; $display("FAIL wrap_first: got C%0d want C9", first); end
    checks++; if (rd_bad !== 0) begin failures++; $display("FAIL wrap_rwds: got %0d bad beats want 0", rd_bad); end
    for (int k = 0; k < 18; k++) begin
      want = 16'h1000 + 16'((14 + k) % 16);
      checks++; if (rd_dat[k] !== want) begin failures++; $display("FAIL wrap_beat%0d: got %h want %h", k, rd_dat[k], want); end
    end
  endtask

  task automatic test_abort;
    int first;
    drive_ca(16'h2000, 16'h0002, 16'h0000, 1'b0);
    dq_i = 16'hDEAD;
    tick; tick;
    cs_ni = 1'b1; refresh_req_i = 1'b0;
    tick;
    checks++; if (dq_oe_o !== 1'b0) begin failures++; $display("FAIL abort_dq_oe: got %b want 0", dq_oe_o); end
    checks++; if (rwds_oe_o !== 1'b0) begin failures++; $display("FAIL abort_rwds_oe: got %b want 0", rwds_oe_o); end
    do_read(16'hA000, 16'h0002, 16'h0000, 1'b0, 2, first);
    checks++; if (rec_oe[0] !== 1'b1) begin failures++; $display("FAIL abort_next_c0: got rwds_oe %b want 1", rec_oe[0]); end
    checks++; if (first !== 9) begin failures++; $display("FAIL abort_next_first: got C%0d want C9", first); end
    checks++; if (rd_dat[0] !== 16'h1000) begin failures++; $display("FAIL abort_mem0: got %h want 1000", rd_dat[0]); end
    checks++; if (rd_dat[1] !== 16'h1001) begin failures++; $display("FAIL abort_mem1: got %h want 1001", rd_dat[1]); end
  endtask

  task automatic test_reset_mid_read;
    int first;
    drive_ca(16'hA000, 16'h0002, 16'h0000, 1'b0);
    dq_i = 16'h0;
    for (int n = 3; n <= 10; n++) tick;
    checks++; if (dq_o !== 16'h1001 || dq_oe_o !== 1'b1) begin failures++; $display("FAIL rst_pre_beat1: got %h oe %b want 1001 oe 1", dq_o, dq_oe_o); end
    rst_i = 1'b1;
    tick;
    checks++; if (dq_oe_o !== 1'b0) begin failures++; $display("FAIL rst_mid_dq_oe: got %b want 0", dq_oe_o); end
    checks++; if (rwds_oe_o !== 1'b0) begin failures++; $display("FAIL rst_mid_rwds_oe: got %b want 0", rwds_oe_o); end
    checks++; if (dq_o !== 16'h0) begin failures++; $display("FAIL rst_mid_dq: got %h want 0000", dq_o); end
    rst_i = 1'b0; cs_ni = 1'b1; refresh_req_i = 1'b0;
    tick;
    do_read(16'hC000, 16'h0100, 16'h0000, 1'b0, 1, first);
    checks++; if (rec_rwds[0] !== 2'b11) begin failures++; $display("FAIL rst_after_ca_rwds: got %b want 11", rec_rwds[0]); end
    checks++; if (first !== 15) begin failures++; $display("FAIL rst_after_first: got C%0d want C15", first); end
    checks++; if (rd_dat[0] !== 16'h8F1F) begin failures++; $display("FAIL rst_after_cr0: got %h want 8f1f", rd_dat[0]); end
  endtask

  initial begin
    test_reset;
    test_write_linear;
    test_cr0_write;
    test_wrap;
    test_abort;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
